// File: rtl/ro_puf_array_if.sv
// Control/response bundle for ro_puf_array. The slave side is the PUF block.
// The master side is the key/ID logic, or a test driver.
interface ro_puf_array_if #(
  parameter int NUM_RO    = 16,
  parameter int RESP_BITS = 8
);
  localparam int IDX_W = $clog2(NUM_RO);

  logic                 start;
  logic [IDX_W-1:0]     challenge;
  logic                 busy;
  logic                 done;
  logic                 resp_valid;
  logic [RESP_BITS-1:0] resp;
  logic [RESP_BITS-1:0] unstable;
  logic                 puf_bit_out;
  logic                 led_on;

  modport slave (
    input  start, challenge,
    output busy, done, resp_valid, resp, unstable, puf_bit_out, led_on
  );

  modport master (
    output start, challenge,
    input  busy, done, resp_valid, resp, unstable, puf_bit_out, led_on
  );
endinterface

// File: rtl/ro_puf_array.sv
// Ring-oscillator PUF response generator.
// It counts synchronized RO edges over a fixed window, then compares
// challenge-rotated oscillator pairs one bit per cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; the last response is held
// CLEAR   | zero the edge counters, the window counter and the bit index
// COUNT   | count RO edges for WINDOW cycles
// COMPARE | one response/unstable bit per cycle, RESP_BITS cycles
// DONE    | one-cycle done pulse; resp_valid is already high
module ro_puf_array #(
  parameter int NUM_RO    = 16,
  parameter int RESP_BITS = 8,
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1024,
  parameter int THRESH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_RO-1:0] ro_in,
  ro_puf_array_if.slave     bus
);
  localparam int IDX_W = $clog2(NUM_RO);
  localparam int BI_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int WIN_W = $clog2(WINDOW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COUNT, S_COMPARE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [NUM_RO-1:0]    sync1, sync2, sync3, edge_det;
  logic [CNT_W-1:0]     cnt [NUM_RO];
  logic [WIN_W-1:0]     win_cnt;
  logic [BI_W-1:0]      bit_idx;
  logic [IDX_W-1:0]     chal_q, idx_a, idx_b;
  logic [RESP_BITS-1:0] resp_q, unstable_q;
  logic                 valid_q;
  logic                 win_last, bit_last;
  logic                 busy_c, done_c;
  logic                 gt;
  logic                 near;
  logic [CNT_W:0]       diff;

  assign win_last = (win_cnt == WIN_W'(WINDOW - 1));
  assign bit_last = (bit_idx == BI_W'(RESP_BITS - 1));
  assign edge_det = sync2 & ~sync3;

  // Pair indices wrap naturally because NUM_RO is a power of two.
  assign idx_a = IDX_W'({bit_idx, 1'b0}) + chal_q;
  assign idx_b = idx_a + IDX_W'(1);

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Saturating edge counters; they are live only in COUNT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RO; i++) cnt[i] <= '0;
    end else if (state == S_CLEAR) begin
      for (int i = 0; i < NUM_RO; i++) cnt[i] <= '0;
    end else if (state == S_COUNT) begin
      for (int i = 0; i < NUM_RO; i++)
        if (edge_det[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  // Window timer and compare bit index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_cnt <= '0;
      bit_idx <= '0;
    end else if (state == S_CLEAR) begin
      win_cnt <= '0;
      bit_idx <= '0;
    end else if (state == S_COUNT) begin
      if (!win_last) win_cnt <= win_cnt + WIN_W'(1);
    end else if (state == S_COMPARE) begin
      if (!bit_last) bit_idx <= bit_idx + BI_W'(1);
    end
  end

  // Pair comparison with an extra bit, so the distance never overflows.
  always_comb begin
    gt   = (cnt[idx_a] > cnt[idx_b]);
    diff = '0;
    if (gt) diff = {1'b0, cnt[idx_a]} - {1'b0, cnt[idx_b]};
    else    diff = {1'b0, cnt[idx_b]} - {1'b0, cnt[idx_a]};
    near = (diff <= (CNT_W + 1)'(THRESH));
  end

  // Challenge latch, response bits and the valid flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chal_q     <= '0;
      resp_q     <= '0;
      unstable_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        chal_q  <= bus.challenge;
        valid_q <= 1'b0;
      end
      if (state == S_COMPARE) begin
        resp_q[bit_idx]     <= gt;
        unstable_q[bit_idx] <= near;
        // Setting valid on the last compare edge raises it together with done.
        if (bit_last) valid_q <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE:    if (bus.start) state_nxt = S_CLEAR;
      S_CLEAR: begin
        busy_c    = 1'b1;
        state_nxt = S_COUNT;
      end
      S_COUNT: begin
        busy_c = 1'b1;
        if (win_last) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        busy_c = 1'b1;
        if (bit_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.resp_valid  = valid_q;
  assign bus.resp        = resp_q;
  assign bus.unstable    = unstable_q;
  assign bus.puf_bit_out = valid_q & resp_q[0];
  assign bus.led_on      = valid_q & (unstable_q == '0);

endmodule

// File: tb/tb_ro_puf_array.sv
// Bench for ro_puf_array with two instances.
// Instance A: CNT_W=8, oscillator periods 4/8/16/4 clocks.
// Instance B: CNT_W=4, oscillator periods 2/4 clocks, to exercise saturation.
module tb_ro_puf_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] cyc = 4'd0;
  logic [3:0] ro_a, ro_b;

  // Oscillator stand-ins advance on the falling edge, away from the sampling edge.
  initial forever begin
    @(negedge clk);
    cyc = cyc + 4'd1;
  end

  // ro[0] and ro[3] share one waveform (period 4); ro[1] has period 8; ro[2] has period 16.
  assign ro_a = {cyc[1], cyc[3], cyc[2], cyc[1]};
  // ro[0] has period 2 and ro[1] period 4; both counts saturate at 15.
  assign ro_b = {2'b00, cyc[1], cyc[0]};

  ro_puf_array_if #(.NUM_RO(4), .RESP_BITS(2)) ifa ();
  ro_puf_array_if #(.NUM_RO(4), .RESP_BITS(2)) ifb ();

  ro_puf_array #(.NUM_RO(4), .RESP_BITS(2), .CNT_W(8), .WINDOW(64), .THRESH(1)) dut_a (
    .clk(clk), .rst(rst), .ro_in(ro_a), .bus(ifa));
  ro_puf_array #(.NUM_RO(4), .RESP_BITS(2), .CNT_W(4), .WINDOW(64), .THRESH(1)) dut_b (
    .clk(clk), .rst(rst), .ro_in(ro_b), .bus(ifb));

  typedef struct {
    logic [1:0] resp;
    logic [1:0] uns;
    logic       led;
    logic       puf;
  } exp_t;

  typedef struct {
    int         sel;
    logic [1:0] chal;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [1:0] c);
    if (sel == 0) begin ifa.start = s; ifa.challenge = c; end
    else          begin ifb.start = s; ifb.challenge = c; end
  endtask

  task automatic get_outs(input int sel, output logic b, output logic d, output logic rv,
                          output logic [1:0] r, output logic [1:0] u,
                          output logic p, output logic l);
    if (sel == 0) begin
      b = ifa.busy; d = ifa.done; rv = ifa.resp_valid; r = ifa.resp;
      u = ifa.unstable; p = ifa.puf_bit_out; l = ifa.led_on;
    end else begin
      b = ifb.busy; d = ifb.done; rv = ifb.resp_valid; r = ifb.resp;
      u = ifb.unstable; p = ifb.puf_bit_out; l = ifb.led_on;
    end
  endtask

  function automatic vec_t mk(int sel, logic [1:0] c, logic [1:0] r, logic [1:0] u, logic l, logic p);
    vec_t v;
    v.sel = sel; v.chal = c;
    v.exp.resp = r; v.exp.uns = u; v.exp.led = l; v.exp.puf = p;
    return v;
  endfunction

  // One full evaluation. The challenge is changed right after acceptance to show it is latched.
  task automatic run_vec(input vec_t v);
    logic b, d, rv, p, l;
    logic [1:0] r, u;
    exp_t e;
    int lat;
    sb.push_back(v.exp);
    @(negedge clk); drive(v.sel, 1'b1, v.chal);
    @(negedge clk); drive(v.sel, 1'b0, v.chal + 2'd1);
    get_outs(v.sel, b, d, rv, r, u, p, l);
    chk("busy_in_clear", b, 1);
    chk("valid_dropped", rv, 0);
    lat = 0;
    for (int k = 2; k <= 200; k++) begin
      @(negedge clk);
      get_outs(v.sel, b, d, rv, r, u, p, l);
      if (d) begin lat = k; break; end
    end
    chk("done_latency", lat, 68);
    e = sb.pop_front();
    if (lat != 0) begin
      chk("resp", r, e.resp);
      chk("unstable", u, e.uns);
      chk("led_on", l, e.led);
      chk("puf_bit_out", p, e.puf);
      chk("busy_at_done", b, 0);
      chk("valid_at_done", rv, 1);
      @(negedge clk);
      get_outs(v.sel, b, d, rv, r, u, p, l);
      chk("done_one_cycle", d, 0);
      chk("valid_held", rv, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b, d, rv, p, l;
    logic [1:0] r, u;
    int bad, ndone;
    exp_t e;

    // Challenge 0: pairs (0,1),(2,3). Challenge 1: (1,2),(3,0) with an exact tie.
    // Challenge 2: (2,3),(0,1). Challenge 3: (3,0) tie,(1,2).
    tbl[0] = mk(0, 2'd0, 2'b01, 2'b00, 1'b1, 1'b1);
    tbl[1] = mk(0, 2'd1, 2'b01, 2'b10, 1'b0, 1'b1);
    tbl[2] = mk(0, 2'd2, 2'b10, 2'b00, 1'b1, 1'b0);
    tbl[3] = mk(0, 2'd3, 2'b10, 2'b01, 1'b0, 1'b0);
    // Saturated tie on pair (0,1); idle ro[2]/ro[3] tie at 0.
    tbl[4] = mk(1, 2'd0, 2'b00, 2'b11, 1'b0, 1'b0);

    rst = 1'b0;
    drive(0, 1'b0, 2'd0);
    drive(1, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    get_outs(0, b, d, rv, r, u, p, l);
    chk("reset_outs_a", {b, d, rv, r, u, p, l}, 0);
    get_outs(1, b, d, rv, r, u, p, l);
    chk("reset_outs_b", {b, d, rv, r, u, p, l}, 0);
    rst = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifa.busy || ifb.busy) bad++;
    end
    chk("idle_no_busy", bad, 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Start pulses during an evaluation are ignored; exactly one done is expected.
    sb.push_back(tbl[0].exp);
    @(negedge clk); drive(0, 1'b1, 2'd0);
    ndone = 0;
    r = '0; u = '0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      drive(0, (k == 5 || k == 40), 2'd1);
      if (ifa.done) begin ndone++; r = ifa.resp; u = ifa.unstable; end
    end
    drive(0, 1'b0, 2'd0);
    chk("single_done", ndone, 1);
    e = sb.pop_front();
    chk("resp_ignored_starts", r, e.resp);
    chk("uns_ignored_starts", u, e.uns);

    // Reset in the middle of COUNT aborts without flagging a result.
    @(negedge clk); drive(0, 1'b1, 2'd0);
    @(negedge clk); drive(0, 1'b0, 2'd0);
    repeat (30) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", ifa.busy, 0);
    chk("abort_valid", ifa.resp_valid, 0);
    chk("abort_resp", ifa.resp, 0);
    rst = 1'b1;
    @(negedge clk);
    run_vec(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
